// File: rtl/vga_text_overlay.sv
// vga_text_overlay: draws a scalable, blinking NUM_CHAR-glyph text box over the VGA pixel stream (RGB565, 2-cycle latency).
module vga_text_overlay #(
  parameter int          H_DISP       = 640,
  parameter int          V_DISP       = 480,
  parameter int          NUM_CHAR     = 4,
  parameter int          CHAR_W       = 16,
  parameter int          CHAR_H       = 16,
  parameter int          POS_X_RST    = 288,
  parameter int          POS_Y_RST    = 232,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [15:0] SCREEN_COLOR = 16'h0000,
  localparam int         ROW_W        = NUM_CHAR * CHAR_W,
  localparam int         RW           = $clog2(CHAR_H)
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic [9:0]       pixel_xpos,
  input  logic [9:0]       pixel_ypos,
  input  logic             frame_start,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic [1:0]       scale,
  input  logic             blink_en,
  input  logic [15:0]      fg_color,
  input  logic [15:0]      bg_color,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [ROW_W-1:0] wr_data,
  output logic [15:0]      pixel_data
);
  localparam int CW = $clog2(ROW_W);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(ROW_W - 1);

  logic [9:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [1:0]       cur_shift_q, cur_shift_d;
  logic             blink_en_q, blink_en_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             hit_q, hit_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [15:0]      pixel_data_q, pixel_data_d;
  logic [ROW_W-1:0] glyph_q [CHAR_H];

  logic [10:0] x_w, y_w, cx, cy, box_w, box_h, dx, dy;
  logic        wrap, glyph_bit;

  assign pixel_data = pixel_data_q;

  // Position, scale and blink enable only change at frame boundaries to avoid tearing.
  always_comb begin
    cur_x_d       = frame_start ? pos_x : cur_x_q;
    cur_y_d       = frame_start ? pos_y : cur_y_q;
    cur_shift_d   = !frame_start ? cur_shift_q : scale == 2'd0 ? 2'd0 : scale == 2'd1 ? 2'd1 : 2'd2;
    blink_en_d    = frame_start ? blink_en : blink_en_q;
    wrap          = blink_cnt_q == BW'(BLINK_FRAMES - 1);
    blink_cnt_d   = !frame_start ? blink_cnt_q : (!blink_en_q || wrap) ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = !frame_start ? blink_phase_q : !blink_en_q ? 1'b1 : wrap ? ~blink_phase_q : blink_phase_q;
  end

  // 11-bit bounds so a box near the right/bottom edge never wraps back to 0.
  always_comb begin
    x_w   = {1'b0, pixel_xpos};
    y_w   = {1'b0, pixel_ypos};
    cx    = {1'b0, cur_x_q};
    cy    = {1'b0, cur_y_q};
    box_w = 11'(ROW_W) << cur_shift_q;
    box_h = 11'(CHAR_H) << cur_shift_q;
    dx    = x_w - cx;
    dy    = y_w - cy;
    hit_d = x_w >= cx && x_w < cx + box_w && y_w >= cy && y_w < cy + box_h &&
            x_w < 11'(H_DISP) && y_w < 11'(V_DISP);
    col_d = CW'(dx >> cur_shift_q);
    row_d = RW'(dy >> cur_shift_q);
  end

  always_comb begin
    glyph_bit    = glyph_q[row_q][COL_MAX - col_q];
    pixel_data_d = !hit_q ? SCREEN_COLOR : (glyph_bit && blink_phase_q) ? fg_color : bg_color;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cur_x_q       <= 10'(POS_X_RST);
      cur_y_q       <= 10'(POS_Y_RST);
      cur_shift_q   <= '0;
      blink_en_q    <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      hit_q         <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      pixel_data_q  <= '0;
    end else begin
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      cur_shift_q   <= cur_shift_d;
      blink_en_q    <= blink_en_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hit_q         <= hit_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pixel_data_q  <= pixel_data_d;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (wr_en && 32'(wr_row) < CHAR_H) glyph_q[wr_row] <= wr_data;
  end
endmodule

// File: tb/tb_vga_text_overlay.sv
// tb_vga_text_overlay: directed and randomized checks of vga_text_overlay against a pixel-level reference model.
module tb_vga_text_overlay;
  localparam int BF = 2;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [9:0]  pixel_xpos = '0, pixel_ypos = '0, pos_x = 10'd288, pos_y = 10'd232;
  logic        frame_start = 1'b0, blink_en = 1'b0, wr_en = 1'b0;
  logic [1:0]  scale = '0;
  logic [15:0] fg_color = 16'hF800, bg_color = 16'h001F;
  logic [3:0]  wr_row = '0;
  logic [63:0] wr_data = '0;
  logic [15:0] pixel_data;

  vga_text_overlay #(.BLINK_FRAMES(BF)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .blink_en(blink_en),
    .fg_color(fg_color), .bg_color(bg_color), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .pixel_data(pixel_data)
  );

  always #5 vga_clk = ~vga_clk;

  int total = 0, bad = 0;
  int m_x = 288, m_y = 232, m_sh = 0, m_k = 0;
  bit m_en = 0, m_phase = 1;
  logic [63:0] m_glyph [16];

  function automatic logic [15:0] model_px(input int x, input int y);
    int s, c, r;
    s = 1 << m_sh;
    if (x >= m_x && x < m_x + 64 * s && y >= m_y && y < m_y + 16 * s && x < 640 && y < 480) begin
      c = (x - m_x) / s;
      r = (y - m_y) / s;
      return (m_glyph[r][63 - c] && m_phase) ? fg_color : bg_color;
    end
    return 16'h0000;
  endfunction

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic expect_px(input logic [15:0] e, input string tag);
    total++;
    assert (pixel_data === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, pixel_data, e);
    end
  endtask

  task automatic chk(input int x, input int y, input string tag);
    logic [15:0] e;
    pixel_xpos = 10'(x);
    pixel_ypos = 10'(y);
    e = model_px(x, y);
    tick;
    tick;
    expect_px(e, $sformatf("%s(%0d,%0d)", tag, x, y));
  endtask

  task automatic frame;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    m_k = m_en ? m_k + 1 : 0;
    m_phase = ((m_k / BF) % 2) == 0;
    m_x = int'(pos_x);
    m_y = int'(pos_y);
    m_sh = scale == 2'd0 ? 0 : scale == 2'd1 ? 1 : 2;
    m_en = blink_en;
  endtask

  task automatic wr(input int row, input logic [63:0] data);
    wr_en = 1'b1;
    wr_row = 4'(row);
    wr_data = data;
    tick;
    wr_en = 1'b0;
    m_glyph[row] = data;
  endtask

  task automatic model_reset;
    m_x = 288; m_y = 232; m_sh = 0; m_k = 0; m_en = 0; m_phase = 1;
  endtask

  initial begin
    int w, h, x, y;
    logic [15:0] e;
    repeat (3) tick;
    expect_px(16'h0000, "reset_px");
    sys_rst = 1'b0;
    for (int r = 0; r < 16; r++) wr(r, 64'h0);
    wr(0, 64'h8000_0000_0000_0001);
    frame;
    chk(288, 232, "s0_left");
    chk(289, 232, "s0_bg");
    chk(351, 232, "s0_right");
    chk(352, 232, "s0_past");
    chk(287, 232, "s0_before");
    chk(288, 248, "s0_below");

    scale = 2'd1;
    frame;
    chk(288, 232, "s1_a");
    chk(289, 233, "s1_b");
    chk(290, 232, "s1_bg");
    chk(415, 232, "s1_right");
    chk(416, 232, "s1_past");
    chk(288, 264, "s1_below");

    pos_x = 10'd0;
    chk(288, 232, "shadow_hold");
    scale = 2'd0;
    frame;
    chk(0, 232, "moved_new");
    chk(288, 232, "moved_old");

    pos_x = 10'd600;
    frame;
    chk(600, 232, "edge_left");
    chk(639, 232, "edge_last");
    chk(640, 232, "edge_off");
    chk(10, 232, "edge_nowrap");

    pos_x = 10'd288;
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      frame;
      chk(288, 232, $sformatf("blink%0d", f));
    end
    blink_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      frame;
      chk(288, 232, $sformatf("noblink%0d", f));
    end

    pixel_xpos = 10'd288;
    pixel_ypos = 10'd232;
    e = model_px(288, 232);
    tick;
    wr_en = 1'b1; wr_row = 4'd0; wr_data = 64'h0;
    tick;
    wr_en = 1'b0;
    m_glyph[0] = 64'h0;
    expect_px(e, "wr_old_bit");
    e = model_px(288, 232);
    tick;
    expect_px(e, "wr_new_bit");

    wr(0, 64'hFFFF_0000_FFFF_0000);
    pos_x = 10'd0;
    scale = 2'd2;
    frame;
    chk(4, 232, "pre_rst");
    sys_rst = 1'b1;
    tick;
    expect_px(16'h0000, "rst_mid");
    tick;
    sys_rst = 1'b0;
    model_reset;
    chk(288, 232, "post_rst_pos");
    chk(4, 232, "post_rst_old");
    chk(352, 232, "post_rst_scale");

    for (int round = 0; round < 8; round++) begin
      pos_x = 10'($urandom_range(0, 1000));
      pos_y = 10'($urandom_range(0, 500));
      scale = 2'($urandom_range(0, 3));
      fg_color = 16'($urandom);
      bg_color = 16'($urandom);
      for (int r = 0; r < 16; r++) wr(r, {$urandom, $urandom});
      blink_en = 1'($urandom_range(0, 1));
      frame;
      frame;
      w = 64 << m_sh;
      h = 16 << m_sh;
      for (int i = 0; i < 30; i++) begin
        x = m_x + $urandom_range(0, w + 16) - 8;
        y = m_y + $urandom_range(0, h + 16) - 8;
        x = x < 0 ? 0 : x > 1023 ? 1023 : x;
        y = y < 0 ? 0 : y > 1023 ? 1023 : y;
        chk(x, y, $sformatf("rnd%0d", round));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
